// File: rtl/sort_host.sv
// sort_host: host driver for the exchange sorter; fills the register file from an LFSR,
// kicks the sorter, then verifies descending order and a sum checksum on readback.
module sort_host #(
    parameter int AW = 5,
    parameter int DW = 16,
    parameter logic [DW-1:0] SEED = 16'hACE1,
    parameter int TMO = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW-1:0] seed_in_i,
    output logic          exe_o,
    input  logic          busy_i,
    input  logic [15:0]   delay_i,
    output logic          we_o,
    output logic [AW-1:0] wa_o,
    output logic [DW-1:0] wd_o,
    output logic [AW-1:0] rd_addr_o,
    input  logic [DW-1:0] rd_data_i,
    output logic          done_o,
    output logic          pass_o,
    output logic [1:0]    err_code_o,
    output logic [AW-1:0] err_addr_o,
    output logic [15:0]   cycles_o
);
    localparam int SW = DW + AW;
    localparam int TW = $clog2(TMO) + 1;
    typedef enum logic [2:0] {IDLE, FILL, KICK, WAIT_HI, WAIT_LO, CHECK, DONE} state_t;
    state_t        state_q;
    logic [DW-1:0] lfsr_q, prev_q, lfsr_d;
    logic [AW-1:0] idx_q;
    logic [SW-1:0] sum_w_q, sum_r_q, sum_r_d;
    logic [TW-1:0] timer_q;
    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[DW-1:1]} ^ (lfsr_q[0] ? DW'(16'hB400) : '0);
        sum_r_d = sum_r_q + SW'(rd_data_i);
    end
    // Write/kick/read strobes decode straight from state so reset drops them at once.
    assign exe_o     = state_q == KICK;
    assign we_o      = state_q == FILL;
    assign wa_o      = we_o ? idx_q : '0;
    assign wd_o      = we_o ? lfsr_q : '0;
    assign rd_addr_o = state_q == CHECK ? idx_q : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= '0;
            prev_q     <= '0;
            idx_q      <= '0;
            sum_w_q    <= '0;
            sum_r_q    <= '0;
            timer_q    <= '0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            err_code_o <= 2'd0;
            err_addr_o <= '0;
            cycles_o   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start_i) begin
                    lfsr_q     <= seed_in_i == '0 ? SEED : seed_in_i;
                    idx_q      <= '0;
                    sum_w_q    <= '0;
                    done_o     <= 1'b0;
                    pass_o     <= 1'b0;
                    err_code_o <= 2'd0;
                    err_addr_o <= '0;
                    state_q    <= FILL;
                end
                FILL: begin
                    sum_w_q <= sum_w_q + SW'(lfsr_q);
                    lfsr_q  <= lfsr_d;
                    idx_q   <= idx_q + AW'(1);
                    if (&idx_q) state_q <= KICK;
                end
                KICK: begin
                    timer_q <= '0;
                    state_q <= WAIT_HI;
                end
                WAIT_HI: if (busy_i) state_q <= WAIT_LO;
                else if (timer_q == TW'(TMO - 1)) begin
                    err_code_o <= 2'd3;
                    done_o     <= 1'b1;
                    state_q    <= DONE;
                end else timer_q <= timer_q + TW'(1);
                WAIT_LO: if (!busy_i) begin
                    cycles_o <= delay_i;
                    idx_q    <= '0;
                    sum_r_q  <= '0;
                    state_q  <= CHECK;
                end
                CHECK: if (idx_q != '0 && rd_data_i > prev_q) begin
                    err_code_o <= 2'd1;
                    err_addr_o <= idx_q;
                    done_o     <= 1'b1;
                    state_q    <= DONE;
                end else begin
                    prev_q  <= rd_data_i;
                    sum_r_q <= sum_r_d;
                    idx_q   <= idx_q + AW'(1);
                    if (&idx_q) begin
                        err_code_o <= sum_r_d != sum_w_q ? 2'd2 : 2'd0;
                        pass_o     <= sum_r_d == sum_w_q;
                        done_o     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_host.sv
// tb_sort_host: table-driven runs against a behavioural sorter plus reset and start-hold sequences.
module tb_sort_host;
    localparam int TMO = 4;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, busy = 1'b0;
    logic [15:0] seed_in = '0, delay = '0, wd, rd_data, cycles;
    logic        exe, we, done, pass;
    logic [4:0]  wa, rd_addr, err_addr;
    logic [1:0]  err_code;
    logic [15:0] mem [32];
    logic [15:0] sw_mem [32];
    logic        sw_en = 1'b0;
    int          checks = 0, errors = 0, exe_cnt = 0;

    sort_host #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start_i(start), .seed_in_i(seed_in), .exe_o(exe),
        .busy_i(busy), .delay_i(delay), .we_o(we), .wa_o(wa), .wd_o(wd),
        .rd_addr_o(rd_addr), .rd_data_i(rd_data), .done_o(done), .pass_o(pass),
        .err_code_o(err_code), .err_addr_o(err_addr), .cycles_o(cycles)
    );

    always #5 clk = ~clk;
    assign rd_data = mem[rd_addr];
    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
        else if (sw_en) for (int i = 0; i < 32; i++) mem[i] <= sw_mem[i];
    end
    always @(negedge clk) if (exe) exe_cnt++;

    function automatic logic [15:0] nxt(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          mode;
        logic [15:0] seed;
        int          dly;
        logic        ep;
        logic [1:0]  ee;
        logic [4:0]  ea;
    } vec_t;
    vec_t tbl [4];

    // mode 0 sorts, 1 never goes busy, 2 plants 0000/FFFF at 5/6, 3 zeroes the minimum
    task automatic run(input int mode, input logic [15:0] seed, input int dly, input logic hold,
                       input logic ep, input logic [1:0] ee, input logic [4:0] ea);
        int n, e0;
        logic [15:0] w, t;
        logic ok;
        @(negedge clk);
        seed_in = seed;
        start = 1'b1;
        e0 = exe_cnt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = hold;
        end while (!exe && n < 100);
        chk("start_to_exe", 64'(n), 64'd33);
        w = seed == 16'h0 ? 16'hACE1 : seed;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (mem[i] !== w) ok = 1'b0;
            w = nxt(w);
        end
        chk("fill_words", 64'(ok), 64'd1);
        if (mode == 1) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!done && n < 100);
            chk("timeout_latency", 64'(n), 64'(TMO + 1));
        end else begin
            for (int i = 0; i < 32; i++) sw_mem[i] = mem[i];
            for (int i = 0; i < 31; i++)
                for (int j = 0; j < 31 - i; j++)
                    if (sw_mem[j] < sw_mem[j+1]) begin
                        t = sw_mem[j]; sw_mem[j] = sw_mem[j+1]; sw_mem[j+1] = t;
                    end
            if (mode == 2) begin sw_mem[5] = 16'h0000; sw_mem[6] = 16'hFFFF; end
            if (mode == 3) sw_mem[31] = 16'h0000;
            busy = 1'b1;
            sw_en = 1'b1;
            @(negedge clk);
            sw_en = 1'b0;
            repeat (dly - 1) @(negedge clk);
            delay = 16'(dly);
            busy = 1'b0;
            n = 0;
            do begin @(negedge clk); n++; end while (!done && n < 200);
            if (ee != 2'd1) chk("busy_to_done", 64'(n), 64'd33);
            chk("cycles", 64'(cycles), 64'(dly));
        end
        start = 1'b0;
        chk("done", 64'(done), 64'd1);
        chk("pass", 64'(pass), 64'(ep));
        chk("err_code", 64'(err_code), 64'(ee));
        chk("err_addr", 64'(err_addr), 64'(ea));
        repeat (3) @(negedge clk);
        chk("exe_per_run", 64'(exe_cnt - e0), 64'd1);
        chk("done_held", 64'(done), 64'd1);
    endtask

    initial begin
        int n;
        tbl[0] = '{0, 16'h0000, 20, 1'b1, 2'd0, 5'd0};
        tbl[1] = '{1, 16'h1234, 0, 1'b0, 2'd3, 5'd0};
        tbl[2] = '{2, 16'h5A5A, 25, 1'b0, 2'd1, 5'd6};
        tbl[3] = '{3, 16'hBEEF, 30, 1'b0, 2'd2, 5'd0};
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {exe, we, wa, wd, rd_addr, done, pass, err_code, err_addr, cycles}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_no_exe", 64'(exe_cnt), 64'd0);
        for (int i = 0; i < 4; i++)
            run(tbl[i].mode, tbl[i].seed, tbl[i].dly, 1'b0, tbl[i].ep, tbl[i].ee, tbl[i].ea);
        @(negedge clk);
        seed_in = 16'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(we && wa == 5'd10) && n < 100) begin @(negedge clk); n++; end
        chk("reach_fill_idx10", 64'(wa), 64'd10);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {exe, we, wa, wd, rd_addr, done, pass, err_code, err_addr, cycles}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 16'h0000, 18, 1'b0, 1'b1, 2'd0, 5'd0);
        run(0, 16'h1234, 17, 1'b1, 1'b1, 2'd0, 5'd0);
        run(0, 16'h0BEE, 22, 1'b0, 1'b1, 2'd0, 5'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
